uart_rx_ctrl: RTL and testbench

// - Receive-side controller for the UART receiver, in the rxclk domain.
// - Gates the receiver through rx_enable and polls rx_empty.
// - Issues the uld_rx_data unload pulse, captures rx_data and buffers bytes in a DEPTH-entry FIFO.
// - Presents the bytes to the host on a valid/ready stream; counts bytes dropped on FIFO overflow.

---
 rtl/uart_rx_ctrl_if.sv | 12 +
 rtl/uart_rx_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
// Host-side byte stream of the UART receive controller. The controller
// drives m_data/m_valid. The host drives m_ready. A byte transfers on every
// rxclk edge where m_valid and m_ready are both high.
interface uart_rx_ctrl_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side controller for the UART receiver (rxclk domain).
//
// Behaviour:
// - Gates the receiver through rx_enable and polls rx_empty.
// - Unloads each pending byte with a three-state IDLE/UNLOAD/CAPTURE
//   sequence.
// - Buffers received bytes in a DEPTH-entry show-ahead FIFO and presents
//   them on a valid/ready stream.
// - Counts bytes dropped because the FIFO was full.
//
// Optional feature:
// - Define RX_IDLE_TIMEOUT_EN to add an idle-data timeout counter.
//   rx_timeout flags data that has sat in the FIFO for TIMEOUT_CYCLES
//   cycles without any push, pop or flush.
// - With RX_IDLE_TIMEOUT_EN undefined, rx_timeout is tied low.
module uart_rx_ctrl #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                   rxclk,
    input  logic                   reset,
    input  logic                   i_ctrl_en,
    input  logic                   i_flush,
    input  logic                   i_drop_clr,
    input  logic                   i_rx_empty,
    input  logic [7:0]             i_rx_data,
    output logic                   o_rx_enable,
    output logic                   o_uld_rx_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [7:0]             o_drop_cnt,
    output logic                   o_rx_timeout,
    uart_rx_ctrl_if.master         m_if
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Reject unusable parameter values at elaboration.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
            $error("uart_rx_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UNLOAD  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_rx_enable;
    logic            r_uld;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_drop_cnt;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_valid;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_drop;

    // Handshake decode.
    // - A push is offered at the edge that closes CAPTURE.
    // - A pop is the host handshake.
    // - flush overrides both.
    // - At full, a push is accepted only if a pop frees the slot in the
    //   same cycle. Otherwise the byte is dropped.
    assign w_push  = (r_state == ST_CAPTURE);
    assign w_valid = (r_level != LW'(0));
    assign w_pop   = w_valid && m_if.m_ready;
    assign w_full  = (r_level == FULL_LEVEL);
    assign w_wr_en = !i_flush && w_push && (!w_full || w_pop);
    assign w_rd_en = !i_flush && w_pop;
    assign w_drop  = !i_flush && w_push && w_full && !w_pop;

    // Receiver enable follows ctrl_en with one cycle of latency.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_rx_enable <= 1'b0;
        end else begin
            r_rx_enable <= i_ctrl_en;
        end
    end

    // Unload sequencer.
    // - It only starts from IDLE, so a ctrl_en drop mid-sequence still
    //   finishes the byte.
    // - The CAPTURE state gives the UART a cycle to raise rx_empty before
    //   IDLE looks at rx_empty again.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_uld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_rx_enable && !i_rx_empty) begin
                        r_state <= ST_UNLOAD;
                        r_uld   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_uld   <= 1'b0;
                    end
                end
                ST_UNLOAD: begin
                    r_state <= ST_CAPTURE;
                    r_uld   <= 1'b0;
                end
                ST_CAPTURE: begin
                    r_state <= ST_IDLE;
                    r_uld   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_uld   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage. rx_data is written directly in the CAPTURE cycle.
    always_ff @(posedge rxclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_rx_data;
        end
    end

    // Pointers and occupancy.
    // - Pointers wrap naturally at DEPTH.
    // - level disambiguates full from empty.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= LW'(0);
        end else if (i_flush) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= LW'(0);
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Drop counter.
    // - It saturates at 255.
    // - A clear coinciding with a drop leaves the count at 1, so that drop
    //   is not lost.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= 8'd0;
        end else if (i_drop_clr) begin
            r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

`ifdef RX_IDLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_idle_cnt;

    // Idle counter.
    // - It restarts on any FIFO activity or while the FIFO is empty.
    // - It holds once it reaches the limit.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= TW'(0);
        end else if (w_push || w_pop || i_flush || (r_level == LW'(0))) begin
            r_idle_cnt <= TW'(0);
        end else if (r_idle_cnt != TO_MAX) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end else begin
            r_idle_cnt <= r_idle_cnt;
        end
    end

    assign o_rx_timeout = (r_idle_cnt == TO_MAX) && (r_level != LW'(0));
`else
    assign o_rx_timeout = 1'b0;
`endif

    assign o_rx_enable   = r_rx_enable;
    assign o_uld_rx_data = r_uld;
    assign o_level       = r_level;
    assign o_drop_cnt    = r_drop_cnt;
    assign m_if.m_data   = r_mem[r_rd_ptr];
    assign m_if.m_valid  = w_valid;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl.
// - A queue-based model tracks the FIFO contents and the drop count.
// - The bench acts as the UART: it offers a byte, waits for the unload
//   pulse, then raises rx_empty.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int M_NONE = 0, M_POP = 1, M_FLUSH = 2, M_CTRL_OFF = 3, M_DCLR = 4;

    logic       rxclk = 1'b0;
    logic       reset;
    logic       ctrl_en, flush, drop_clr, rx_empty;
    logic [7:0] rx_data;
    logic       rx_enable, uld;
    logic [4:0] level;
    logic [7:0] drop_cnt;
    logic       rx_timeout;

    uart_rx_ctrl_if sif ();

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(8)) dut (
        .rxclk         (rxclk),
        .reset         (reset),
        .i_ctrl_en     (ctrl_en),
        .i_flush       (flush),
        .i_drop_clr    (drop_clr),
        .i_rx_empty    (rx_empty),
        .i_rx_data     (rx_data),
        .o_rx_enable   (rx_enable),
        .o_uld_rx_data (uld),
        .o_level       (level),
        .o_drop_cnt    (drop_cnt),
        .o_rx_timeout  (rx_timeout),
        .m_if          (sif.master)
    );

    always #5 rxclk = ~rxclk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];
    int         exp_drop = 0;
    logic [7:0] got_q [$];

    // Act as the UART for one byte and update the model at the push edge.
    task automatic send_byte(input logic [7:0] b, input int mode);
        bit seen = 1'b0;
        bit dropped = 1'b0;
        rx_data  = b;
        rx_empty = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge rxclk);
            if (uld === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL uld_wait byte=%02h got no pulse, required pulse", b);
            rx_empty = 1'b1;
            return;
        end
        if (mode == M_CTRL_OFF) ctrl_en = 1'b0;
        @(negedge rxclk);
        total++;
        if (uld !== 1'b0) begin bad++; $display("FAIL uld_pulse_width got=%b exp=0", uld); end
        rx_empty = 1'b1;
        if (mode == M_POP) begin
            sif.m_ready = 1'b1;
            if (exp_q.size() > 0) begin
                total++;
                if (sif.m_data !== exp_q[0]) begin
                    bad++; $display("FAIL pop_in_capture got=%02h exp=%02h", sif.m_data, exp_q[0]);
                end
            end
        end
        if (mode == M_FLUSH) flush = 1'b1;
        if (mode == M_DCLR) drop_clr = 1'b1;
        @(posedge rxclk);
        if (mode == M_FLUSH) begin
            exp_q.delete();
        end else begin
            if (mode == M_POP && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else dropped = 1'b1;
            if (mode == M_DCLR) exp_drop = dropped ? 1 : 0;
            else if (dropped && exp_drop < 255) exp_drop++;
        end
        @(negedge rxclk);
        flush = 1'b0; drop_clr = 1'b0; sif.m_ready = 1'b0;
    endtask

    // Host drain with m_ready held high; collects bytes into got_q.
    task automatic drain_collect();
        got_q.delete();
        sif.m_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (sif.m_valid !== 1'b1) break;
            got_q.push_back(sif.m_data);
            @(negedge rxclk);
        end
        sif.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_en = 1'b0; flush = 1'b0; drop_clr = 1'b0;
        rx_empty = 1'b1; rx_data = 8'h00; sif.m_ready = 1'b0;
        repeat (2) @(negedge rxclk);
        total += 6;
        if (rx_enable !== 1'b0)  begin bad++; $display("FAIL rst_rx_enable got=%b exp=0", rx_enable); end
        if (uld !== 1'b0)        begin bad++; $display("FAIL rst_uld got=%b exp=0", uld); end
        if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", sif.m_valid); end
        if (level !== 5'd0)      begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
        if (drop_cnt !== 8'd0)   begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
        if (rx_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", rx_timeout); end
        reset = 1'b0;
        @(negedge rxclk);
    endtask

    task automatic test_basic();
        ctrl_en = 1'b1; rx_data = 8'hA5; rx_empty = 1'b0;
        total++;
        if (rx_enable !== 1'b0) begin bad++; $display("FAIL en_latency0 got=%b exp=0", rx_enable); end
        @(negedge rxclk);
        total += 2;
        if (rx_enable !== 1'b1) begin bad++; $display("FAIL en_latency1 got=%b exp=1", rx_enable); end
        if (uld !== 1'b0) begin bad++; $display("FAIL uld_early got=%b exp=0", uld); end
        @(negedge rxclk);
        total++;
        if (uld !== 1'b1) begin bad++; $display("FAIL uld_pulse got=%b exp=1", uld); end
        @(negedge rxclk);
        total += 2;
        if (uld !== 1'b0) begin bad++; $display("FAIL uld_single got=%b exp=0", uld); end
        if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL valid_early got=%b exp=0", sif.m_valid); end
        rx_empty = 1'b1;
        @(negedge rxclk);
        exp_q.push_back(8'hA5);
        total += 3;
        if (sif.m_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", sif.m_valid); end
        if (sif.m_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%02h exp=a5", sif.m_data); end
        if (level !== 5'd1) begin bad++; $display("FAIL basic_level got=%0d exp=1", level); end
        drain_collect();
        total++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            bad++; $display("FAIL basic_drain got_n=%0d exp_n=1", got_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) send_byte(8'(i), M_NONE);
        send_byte(8'hFF, M_NONE);
        total += 2;
        if (level !== 5'(exp_q.size())) begin bad++; $display("FAIL ovf_level got=%0d exp=%0d", level, exp_q.size()); end
        if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        drain_collect();
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_order idx=%0d got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
        end
        total++;
        if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", sif.m_valid); end
        exp_q.delete();
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), M_NONE);
        send_byte(8'h55, M_POP);
        total += 2;
        if (level !== 5'd16) begin bad++; $display("FAIL fpp_level got=%0d exp=16", level); end
        if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL fpp_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        drain_collect();
        total++;
        if (got_q.size() != 16 || got_q[got_q.size()-1] !== 8'h55) begin
            bad++; $display("FAIL fpp_last got_n=%0d exp last=55", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL fpp_order idx=%0d got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_drop_clr();
        drop_clr = 1'b1; @(negedge rxclk); drop_clr = 1'b0; exp_drop = 0;
        total++;
        if (drop_cnt !== 8'd0) begin bad++; $display("FAIL dclr_plain got=%0d exp=0", drop_cnt); end
        for (int i = 0; i < 18; i++) send_byte(8'(i), M_NONE);
        send_byte(8'hEE, M_DCLR);
        total++;
        if (drop_cnt !== 8'd1) begin bad++; $display("FAIL dclr_with_drop got=%0d exp=1", drop_cnt); end
        for (int i = 0; i < 258; i++) send_byte(8'(i), M_NONE);
        total++;
        if (drop_cnt !== 8'(exp_drop) || exp_drop != 255) begin
            bad++; $display("FAIL drop_saturate got=%0d exp=255", drop_cnt);
        end
        drain_collect();
        exp_q.delete();
    endtask

    task automatic test_ctrl_off();
        int pulses = 0;
        send_byte(8'h3C, M_CTRL_OFF);
        total += 2;
        if (level !== 5'd1) begin bad++; $display("FAIL coff_level got=%0d exp=1", level); end
        if (sif.m_data !== 8'h3C) begin bad++; $display("FAIL coff_data got=%02h exp=3c", sif.m_data); end
        rx_data = 8'h77; rx_empty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rxclk);
            if (uld === 1'b1) pulses++;
        end
        total += 2;
        if (pulses != 0) begin bad++; $display("FAIL coff_no_unload got=%0d pulses exp=0", pulses); end
        if (rx_enable !== 1'b0) begin bad++; $display("FAIL coff_enable got=%b exp=0", rx_enable); end
        rx_empty = 1'b1; ctrl_en = 1'b1;
        repeat (2) @(negedge rxclk);
        drain_collect();
        total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin bad++; $display("FAIL coff_drain got_n=%0d exp_n=1", got_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), M_NONE);
        total++;
        if (level !== 5'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", level); end
        send_byte(8'h99, M_FLUSH);
        total += 3;
        if (level !== 5'd0) begin bad++; $display("FAIL flush_level got=%0d exp=0", level); end
        if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", sif.m_valid); end
        if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL flush_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_timeout();
        logic exp_to;
`ifdef RX_IDLE_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        send_byte(8'h12, M_NONE);
        repeat (7) @(negedge rxclk);
        total++;
        if (rx_timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", rx_timeout); end
        @(negedge rxclk);
        total++;
        if (rx_timeout !== exp_to) begin bad++; $display("FAIL to_set got=%b exp=%b", rx_timeout, exp_to); end
        sif.m_ready = 1'b1;
        @(negedge rxclk);
        sif.m_ready = 1'b0;
        total++;
        if (rx_timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", rx_timeout); end
        exp_q.delete();
    endtask

    task automatic test_random();
        drop_clr = 1'b1; @(negedge rxclk); drop_clr = 1'b0; exp_drop = 0;
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 24);
            int guard = 0;
            for (int k = 0; k < n; k++) send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? M_POP : M_NONE);
            total += 2;
            if (level !== 5'(exp_q.size())) begin bad++; $display("FAIL rnd_level r=%0d got=%0d exp=%0d", r, level, exp_q.size()); end
            if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL rnd_drop r=%0d got=%0d exp=%0d", r, drop_cnt, exp_drop); end
            while (exp_q.size() > 0 && guard < 400) begin
                sif.m_ready = 1'($urandom_range(0, 1));
                total++;
                if (sif.m_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid got=%b exp=1", sif.m_valid); end
                if (sif.m_ready) begin
                    total++;
                    if (sif.m_data !== exp_q[0]) begin bad++; $display("FAIL rnd_data got=%02h exp=%02h", sif.m_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                @(negedge rxclk);
                guard++;
            end
            sif.m_ready = 1'b0;
            total++;
            if (sif.m_valid !== 1'b0 || level !== 5'd0) begin
                bad++; $display("FAIL rnd_drained valid=%b level=%0d exp 0/0", sif.m_valid, level);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), M_NONE);
        #2 reset = 1'b1;
        #1;
        total += 3;
        if (level !== 5'd0) begin bad++; $display("FAIL arst_level got=%0d exp=0", level); end
        if (sif.m_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", sif.m_valid); end
        if (rx_enable !== 1'b0) begin bad++; $display("FAIL arst_enable got=%b exp=0", rx_enable); end
        @(negedge rxclk);
        reset = 1'b0;
        exp_q.delete(); exp_drop = 0;
        @(negedge rxclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_drop_clr();
        test_ctrl_off();
        test_flush();
        test_timeout();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
